// File: rtl/rv_muldiv_unit.sv
// M-extension execute unit: iterative MUL_STEP-bit multiplier; restoring divider only when RV_MULDIV_DIV_EN is defined.
// Latency: result after XLEN/MUL_STEP+1 cycles (MUL*), XLEN+1 (DIV*), 1 (div-by-zero, overflow, illegal op).
// Backpressure: holds DONE and o_y while i_stall is high; o_stall holds earlier stages while busy; i_flush drops the op.
module rv_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ce,
    input  logic            i_muldiv,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_stall,
    input  logic            i_flush,
    output logic            o_ce,
    output logic [XLEN-1:0] o_y,
    output logic [4:0]      o_rd_addr,
    output logic            o_wr_rd,
    output logic            o_stall,
    output logic            o_illegal
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(XLEN / MUL_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
`ifdef RV_MULDIV_DIV_EN
        S_DIV,
`endif
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [2:0]      f3;
    logic [4:0]      rd_q;
    logic            sa, sb, ill, done_q, wr_q;
    logic            sa_in, sb_in, accept;
    logic [XLEN-1:0] mag_a, mag_b, y_fin;
    logic [XLEN+MUL_STEP-1:0] pp, sum;
    logic [2*XLEN-1:0] mul_next, prod;
`ifdef RV_MULDIV_DIV_EN
    localparam logic [CW-1:0] DIV_CNT = CW'(XLEN);
    logic            raw;
    logic            ovf;
    logic [XLEN:0]   rsh, diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0] quot, rem;
`endif

    assign accept = i_ce && i_muldiv && !i_flush;
    assign sa_in  = i_rs1[XLEN-1] && (i_funct3 == 3'd1 || i_funct3 == 3'd2 || (i_funct3[2] && !i_funct3[0]));
    assign sb_in  = i_rs2[XLEN-1] && (i_funct3 == 3'd1 || (i_funct3[2] && !i_funct3[0]));
    assign mag_a  = sa_in ? -i_rs1 : i_rs1;
    assign mag_b  = sb_in ? -i_rs2 : i_rs2;

    // Multiplier bits sit in the low half of acc and shift out as the product shifts in.
    assign pp       = {{MUL_STEP{1'b0}}, mcand} * {{XLEN{1'b0}}, acc[MUL_STEP-1:0]};
    assign sum      = {{MUL_STEP{1'b0}}, acc[2*XLEN-1:XLEN]} + pp;
    assign mul_next = {sum, acc[XLEN-1:MUL_STEP]};

`ifdef RV_MULDIV_DIV_EN
    // acc = {partial remainder, dividend/quotient}; mcand holds the divisor magnitude.
    assign ovf      = !i_funct3[0] && i_rs1 == {1'b1, {(XLEN-1){1'b0}}} && i_rs2 == '1;
    assign rsh      = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign diff     = rsh - {1'b0, mcand};
    assign div_next = diff[XLEN] ? {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
`endif

    always_comb begin
        prod  = (sa ^ sb) ? -acc : acc;
        y_fin = (f3 == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef RV_MULDIV_DIV_EN
        quot = acc[XLEN-1:0];
        rem  = acc[2*XLEN-1:XLEN];
        if (f3[2]) begin
            if (raw)
                y_fin = f3[1] ? rem : quot;
            else
                y_fin = f3[1] ? (sa ? -rem : rem) : ((sa ^ sb) ? -quot : quot);
        end
`endif
        if (ill)
            y_fin = '0;
    end

    assign o_stall = (state != S_IDLE && !(state == S_DONE && !i_stall)) || (state == S_IDLE && accept);
    assign o_ce    = done_q && !i_flush;
    assign o_wr_rd = wr_q && !i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            f3        <= '0;
            rd_q      <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            ill       <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            o_y       <= '0;
            o_rd_addr <= '0;
            o_illegal <= 1'b0;
`ifdef RV_MULDIV_DIV_EN
            raw       <= 1'b0;
`endif
        end else if (i_flush) begin
            state     <= S_IDLE;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            o_illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (i_ce && i_muldiv) begin
                    f3   <= i_funct3;
                    rd_q <= i_rd_addr;
                    sa   <= sa_in;
                    sb   <= sb_in;
                    ill  <= 1'b0;
`ifdef RV_MULDIV_DIV_EN
                    raw  <= 1'b0;
`endif
                    if (!i_funct3[2]) begin
                        state <= S_MUL;
                        cnt   <= MUL_CNT;
                        mcand <= mag_a;
                        acc   <= {{XLEN{1'b0}}, mag_b};
                    end else begin
`ifdef RV_MULDIV_DIV_EN
                        state <= S_DIV;
                        mcand <= mag_b;
                        if (i_rs2 == '0) begin
                            cnt <= '0;
                            raw <= 1'b1;
                            acc <= {i_rs1, {XLEN{1'b1}}};
                        end else if (ovf) begin
                            cnt <= '0;
                            raw <= 1'b1;
                            acc <= {{XLEN{1'b0}}, i_rs1};
                        end else begin
                            cnt <= DIV_CNT;
                            acc <= {{XLEN{1'b0}}, mag_a};
                        end
`else
                        // No divider: spend one cycle in MUL with an empty count to report illegal.
                        state <= S_MUL;
                        cnt   <= '0;
                        ill   <= 1'b1;
`endif
                    end
                end
                S_MUL: if (cnt == '0) begin
                    state     <= S_DONE;
                    done_q    <= 1'b1;
                    wr_q      <= (rd_q != 5'd0) && !ill;
                    o_y       <= y_fin;
                    o_rd_addr <= rd_q;
                    o_illegal <= ill;
                end else begin
                    acc <= mul_next;
                    cnt <= cnt - CW'(1);
                end
`ifdef RV_MULDIV_DIV_EN
                S_DIV: if (cnt == '0) begin
                    state     <= S_DONE;
                    done_q    <= 1'b1;
                    wr_q      <= (rd_q != 5'd0);
                    o_y       <= y_fin;
                    o_rd_addr <= rd_q;
                    o_illegal <= 1'b0;
                end else begin
                    acc <= div_next;
                    cnt <= cnt - CW'(1);
                end
`endif
                S_DONE: if (!i_stall) begin
                    state     <= S_IDLE;
                    done_q    <= 1'b0;
                    wr_q      <= 1'b0;
                    o_illegal <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit at XLEN=32, MUL_STEP=4; expectations follow RV_MULDIV_DIV_EN.
module tb_rv_muldiv_unit;
    localparam int XLEN = 32;
    localparam int MUL_STEP = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ce = 1'b0, muldiv = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] rs1 = '0, rs2 = '0;
    logic [4:0]      rd_addr = '0;
    logic            o_ce, o_wr_rd, o_stall, o_illegal;
    logic [XLEN-1:0] o_y;
    logic [4:0]      o_rd_addr;

    rv_muldiv_unit #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_muldiv(muldiv), .i_funct3(funct3),
        .i_rs1(rs1), .i_rs2(rs2), .i_rd_addr(rd_addr), .i_stall(stall), .i_flush(flush),
        .o_ce(o_ce), .o_y(o_y), .o_rd_addr(o_rd_addr), .o_wr_rd(o_wr_rd),
        .o_stall(o_stall), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] y;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb_q[$];
    int errors = 0;
    int checks = 0;

    function automatic exp_t model(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        logic [63:0] sa64, sb64, ua64, ub64, p;
`ifdef RV_MULDIV_DIV_EN
        int ia, ib;
        ia = a;
        ib = b;
`endif
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ua64 = {32'h0, a};
        ub64 = {32'h0, b};
        e.y = '0; e.rd = rd; e.ill = 1'b0; e.lat = 9; e.t0 = 0; p = '0;
        case (f)
            3'd0: begin p = ua64 * ub64; e.y = p[31:0]; end
            3'd1: begin p = sa64 * sb64; e.y = p[63:32]; end
            3'd2: begin p = sa64 * ub64; e.y = p[63:32]; end
            3'd3: begin p = ua64 * ub64; e.y = p[63:32]; end
            default: begin
`ifdef RV_MULDIV_DIV_EN
                e.lat = 33;
                if (b == 32'h0) begin
                    e.lat = 1;
                    e.y = f[1] ? a : 32'hFFFF_FFFF;
                end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lat = 1;
                    e.y = f[1] ? 32'h0 : a;
                end else if (!f[0]) begin
                    e.y = f[1] ? ia % ib : ia / ib;
                end else begin
                    e.y = f[1] ? a % b : a / b;
                end
`else
                e.lat = 1;
                e.ill = 1'b1;
                e.y = '0;
`endif
            end
        endcase
        e.wr = (rd != 5'd0) && !e.ill;
        return e;
    endfunction

    // Compares every new result (rising o_ce) against the oldest outstanding expectation.
    task automatic sb_monitor();
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_ce && !prev) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: o_ce=1 with nothing outstanding, y=%h", o_y);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if (o_y !== e.y) begin errors++; $display("FAIL result_y: got %h want %h", o_y, e.y); end
                    checks++;
                    if (o_rd_addr !== e.rd) begin errors++; $display("FAIL result_rd: got %0d want %0d", o_rd_addr, e.rd); end
                    checks++;
                    if (o_wr_rd !== e.wr) begin errors++; $display("FAIL result_wr_rd: got %b want %b", o_wr_rd, e.wr); end
                    checks++;
                    if (o_illegal !== e.ill) begin errors++; $display("FAIL result_illegal: got %b want %b", o_illegal, e.ill); end
                    checks++;
                    if (cyc - e.t0 !== e.lat) begin errors++; $display("FAIL result_latency: got %0d want %0d", cyc - e.t0, e.lat); end
                end
            end
            prev = o_ce;
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push);
        exp_t e;
        @(negedge clk);
        funct3 = f; rs1 = a; rs2 = b; rd_addr = rd; ce = 1'b1; muldiv = 1'b1;
        e = model(f, a, b, rd);
        #1;
        checks++;
        if (o_stall !== 1'b1) begin errors++; $display("FAIL accept_stall: got %b want 1", o_stall); end
        @(posedge clk);
        #1;
        ce = 1'b0; muldiv = 1'b0;
        e.t0 = cyc;
        if (push) sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d outstanding after %0d cycles, want 0", sb_q.size(), n);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_ce, o_y, o_rd_addr, o_wr_rd, o_illegal, o_stall} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ce=%b y=%h rd=%0d wr=%b ill=%b stall=%b, want all 0",
                     o_ce, o_y, o_rd_addr, o_wr_rd, o_illegal, o_stall);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (o_stall !== 1'b1 || o_ce !== 1'b0) begin
                errors++; $display("FAIL mul_busy_%0d: stall=%b ce=%b want 1/0", k, o_stall, o_ce);
            end
        end
        @(negedge clk);
        checks++;
        if (o_ce !== 1'b1 || o_stall !== 1'b0) begin
            errors++; $display("FAIL mul_done: ce=%b stall=%b want 1/0", o_ce, o_stall);
        end
        wait_drain(50);
    endtask

    task automatic test_mul_family();
        logic [2:0]  f_t [7] = '{3'd3, 3'd2, 3'd1, 3'd1, 3'd0, 3'd2, 3'd3};
        logic [31:0] a_t [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000,
                                 32'h0001_0003, 32'h8000_0001, 32'h0};
        logic [31:0] b_t [7] = '{32'hFFFF_FFFF, 32'd2, 32'd7, 32'h8000_0000,
                                 32'h0002_0005, 32'hFFFF_FFFF, 32'h1234};
        for (int i = 0; i < 7; i++) begin
            issue(f_t[i], a_t[i], b_t[i], 5'(i), 1'b1);
            wait_drain(50);
        end
        for (int i = 0; i < 4; i++) begin
            issue(3'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(1, 31)), 1'b1);
            wait_drain(50);
        end
    endtask

    task automatic test_div();
        logic [2:0]  f_t [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd7};
        logic [31:0] a_t [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'd7, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] b_t [8] = '{32'd2, 32'd2, 32'd7, 32'd7,
                                 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd3, 32'h10};
        for (int i = 0; i < 8; i++) begin
            issue(f_t[i], a_t[i], b_t[i], 5'(i + 10), 1'b1);
            wait_drain(60);
        end
        for (int i = 0; i < 3; i++) begin
            issue(3'($urandom_range(4, 7)), $urandom, $urandom_range(1, 1000), 5'd21, 1'b1);
            wait_drain(60);
        end
    endtask

    task automatic test_special();
        logic [2:0]  f_t [5] = '{3'd5, 3'd4, 3'd6, 3'd7, 3'd6};
        logic [31:0] a_t [5] = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF7};
        logic [31:0] b_t [5] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        for (int i = 0; i < 5; i++) begin
            issue(f_t[i], a_t[i], b_t[i], 5'(i + 1), 1'b1);
            wait_drain(60);
        end
    endtask

    task automatic test_flush();
        int fe;
        int ce_seen;
`ifdef RV_MULDIV_DIV_EN
        fe = 10;
        issue(3'd4, 32'd1000, 32'd7, 5'd3, 1'b0);
`else
        fe = 5;
        issue(3'd0, 32'd1000, 32'd7, 5'd3, 1'b0);
`endif
        repeat (fe) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        checks++;
        if (o_stall !== 1'b1 || o_ce !== 1'b0) begin
            errors++; $display("FAIL flush_cycle: stall=%b ce=%b want 1/0", o_stall, o_ce);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        checks++;
        if (o_stall !== 1'b0 || o_ce !== 1'b0) begin
            errors++; $display("FAIL flush_idle: stall=%b ce=%b want 0/0", o_stall, o_ce);
        end
        ce_seen = 0;
        repeat (40) begin @(negedge clk); if (o_ce) ce_seen++; end
        checks++;
        if (ce_seen != 0) begin errors++; $display("FAIL flush_no_result: o_ce seen %0d cycles want 0", ce_seen); end
        // Flush in the accept cycle must block the accept.
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; rd_addr = 5'd2; ce = 1'b1; muldiv = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL flush_accept_stall: got %b want 0", o_stall); end
        @(posedge clk);
        #1;
        ce = 1'b0; muldiv = 1'b0; flush = 1'b0;
        ce_seen = 0;
        repeat (12) begin @(negedge clk); if (o_ce || o_stall) ce_seen++; end
        checks++;
        if (ce_seen != 0) begin errors++; $display("FAIL flush_accept_dropped: busy/ce %0d cycles want 0", ce_seen); end
    endtask

    task automatic test_stall();
        exp_t e;
        int k;
        e = model(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9);
        stall = 1'b1;
        issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (!o_ce && k < 60);
        checks++;
        if (o_ce !== 1'b1) begin errors++; $display("FAIL stall_wait: o_ce=%b want 1", o_ce); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (o_ce !== 1'b1 || o_y !== e.y || o_stall !== 1'b1) begin
                errors++; $display("FAIL stall_hold_%0d: ce=%b y=%h stall=%b want 1/%h/1", i, o_ce, o_y, o_stall, e.y);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL stall_release: o_stall=%b want 0", o_stall); end
        @(negedge clk);
        checks++;
        if (o_ce !== 1'b0) begin errors++; $display("FAIL stall_exit: o_ce=%b want 0", o_ce); end
        wait_drain(10);
    endtask

    task automatic test_illegal();
        issue(3'd5, 32'd9, 32'd3, 5'd7, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
`ifdef RV_MULDIV_DIV_EN
        if (o_illegal !== 1'b0 || o_ce !== 1'b0) begin
            errors++; $display("FAIL illegal_edge1: ill=%b ce=%b want 0/0", o_illegal, o_ce);
        end
`else
        if (o_illegal !== 1'b1 || o_wr_rd !== 1'b0 || o_ce !== 1'b1 || o_y !== 32'h0) begin
            errors++; $display("FAIL illegal_edge1: ill=%b wr=%b ce=%b y=%h want 1/0/1/0", o_illegal, o_wr_rd, o_ce, o_y);
        end
`endif
        wait_drain(60);
        checks++;
        if (o_illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b want 0", o_illegal); end
    endtask

    task automatic test_back_to_back();
        int k;
        issue(3'd0, 32'd12345, 32'd678, 5'd4, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (!o_ce && k < 40);
        checks++;
        if (o_ce !== 1'b1 || o_stall !== 1'b0) begin
            errors++; $display("FAIL b2b_done: ce=%b stall=%b want 1/0", o_ce, o_stall);
        end
        issue(3'd3, 32'hCAFE_F00D, 32'h0BAD_BEEF, 5'd6, 1'b1);
        wait_drain(60);
    endtask

    task automatic test_non_m();
        int bad = 0;
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; rd_addr = 5'd8; ce = 1'b1; muldiv = 1'b0;
        repeat (6) begin #1; if (o_stall || o_ce) bad++; @(negedge clk); end
        ce = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL non_m_ignored: busy/ce %0d cycles want 0", bad); end
    endtask

    task automatic test_reset_mid();
        int ce_seen = 0;
        issue(3'd2, 32'd5, 32'd6, 5'd11, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({o_ce, o_y, o_rd_addr, o_wr_rd, o_illegal, o_stall} !== '0) begin
            errors++; $display("FAIL reset_mid: ce=%b y=%h rd=%0d stall=%b want all 0", o_ce, o_y, o_rd_addr, o_stall);
        end
        rst_n = 1'b1;
        repeat (15) begin @(negedge clk); if (o_ce) ce_seen++; end
        checks++;
        if (ce_seen != 0) begin errors++; $display("FAIL reset_mid_dropped: o_ce %0d cycles want 0", ce_seen); end
    endtask

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_mul();
        test_mul_family();
        test_div();
        test_special();
        test_flush();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_non_m();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv_muldiv_unit.md
# rv_muldiv_unit

Parametrised multi-cycle M-extension execute unit that sits beside the single-cycle ALU in the execute stage. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands. It uses an iterative multiplier that retires MUL_STEP bits per cycle and a restoring divider that retires 1 bit per cycle. While it is busy it stalls the pipeline through the same ce/stall/flush handshake as the rest of the core.

## Interface
Parameters:
- XLEN, 32: operand and result width; even, ≥ 8.
- MUL_STEP, 4: multiplier bits consumed per cycle; must divide XLEN.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_ce  in  1  clock enable from decode: the current instruction is valid.
- i_muldiv  in  1  the current instruction is an M-extension op.
- i_funct3  in  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rs1, i_rs2  in  XLEN  operand values.
- i_rd_addr  in  5  destination register.
- i_stall  in  1  next stage is stalled.
- i_flush  in  1  flush this stage.
- o_ce  out  1  result valid for the next stage.
- o_y  out  XLEN  result.
- o_rd_addr  out  5  destination register of the result.
- o_wr_rd  out  1  write enable; equals o_ce && o_rd_addr≠0.
- o_stall  out  1  the unit is busy; hold the earlier pipeline stages.
- o_illegal  out  1  illegal op (see Configuration).

## Operation
- FSM states:
  - IDLE: no op in progress.
  - MUL: iterate the multiplier.
  - DIV: iterate the divider.
  - DONE: hold the result until the next stage takes it.
- Accept: in IDLE with i_ce && i_muldiv && !i_flush, latch the operands, funct3 and rd_addr.
  - funct3<4 goes to MUL with counter = XLEN/MUL_STEP.
  - funct3≥4 goes to DIV with counter = XLEN, except for the special cases below, which go straight to DONE.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV and REM: signed.
  - All other ops: unsigned.
  - Signed ops run on magnitudes; the sign is fixed up when entering DONE.
- MUL: each cycle, add the partial product of MUL_STEP multiplier bits into a 2·XLEN accumulator, then decrement the counter. At 0, go to DONE. MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- DIV: each cycle, shift-subtract 1 quotient bit, then decrement the counter. At 0, go to DONE. Quotient sign is sign(rs1)^sign(rs2); remainder sign follows rs1.
- Special cases, taken directly to DONE:
  - rs2=0: quotient = all ones, remainder = rs1.
  - Signed rs1 = −2^(XLEN−1) and rs2 = −1: quotient = rs1, remainder = 0.
- DONE: o_ce=1 and o_y is valid. If !i_stall, go to IDLE next edge; otherwise hold DONE with o_y stable.
- o_stall = (state≠IDLE && !(state==DONE && !i_stall)) || (state==IDLE && i_ce && i_muldiv && !i_flush).
- Flush: i_flush in any state forces IDLE at the next edge; o_ce=0 in that cycle, and no result is ever emitted for the flushed op. Flush has priority over accept and over DONE.
- A non-M op (i_muldiv=0) is ignored; o_ce stays 0.

## Timing
- Reset (i_rst_n=0 at an edge): state=IDLE; o_ce=0, o_y=0, o_rd_addr=0, o_wr_rd=0, o_illegal=0. o_stall becomes 0 once the reset has taken effect. Reset mid-iteration drops the op.
- Latency, counting the accept edge as edge 0; o_ce is high in the cycle after the stated edge:
  - MUL family: edge XLEN/MUL_STEP+1 (9 at defaults).
  - DIV family: edge XLEN+1 (33).
  - Special cases: edge 1.
- Back-to-back: a new op can be accepted in the cycle after DONE exits (IDLE), so there is 1 idle cycle minimum between ops.
- o_y, o_rd_addr and o_wr_rd are registered and change only when entering DONE or on reset.

## Configuration
- RV_MULDIV_DIV_EN defined: divider datapath and DIV state are compiled in; behaviour is as above.
- RV_MULDIV_DIV_EN undefined: there is no divider logic. An accept with funct3≥4 goes directly to DONE with o_y=0, o_wr_rd=0 and o_illegal=1 for the DONE cycle. MUL ops are unchanged.

## Test plan
- MUL rs1=7, rs2=−3 (XLEN=32, MUL_STEP=4) -> o_ce at edge 9, o_y=0xFFFFFFEB, o_stall high on edges 0–8.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> o_y=0xFFFFFFFE; MULHSU rs1=−1, rs2=2 -> o_y=0xFFFFFFFF.
- DIV −7/2 -> o_y=0xFFFFFFFD at edge 33; REM −7/2 -> o_y=0xFFFFFFFF.
- DIVU 5/0 -> o_y=0xFFFFFFFF at edge 1; DIV 0x80000000/−1 -> o_y=0x80000000; REM of the same -> 0.
- DIV accepted, i_flush at edge 10 -> state IDLE at edge 11, o_ce never asserted, o_stall low from edge 11.
- MUL completes while i_stall is high for 3 cycles -> o_ce and o_y held for 3 cycles, then IDLE; with RV_MULDIV_DIV_EN undefined, DIVU -> o_illegal=1, o_wr_rd=0 at edge 1.
